// File: rtl/innovation_covariance_2x2.sv
// Kalman innovation covariance S = H*P*H' + R for a 2x2 measurement model.
// A single shared signed multiplier is time-multiplexed by a small FSM:
// eight products form T = H*P, eight more form T*H' and R is added per
// element. The finished matrix is presented on S together with a one-cycle
// done pulse that can directly start the downstream 2x2 inverter.
module innovation_covariance_2x2 #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [0:1][0:1][WIDTH-1:0]    H,
  input  logic [0:1][0:1][WIDTH-1:0]    P,
  input  logic [0:1][0:1][WIDTH-1:0]    R,
  output logic [0:1][0:1][WIDTH-1:0]    S,
  output logic                          done
);

  localparam int PW = 2 * WIDTH;
  localparam int AW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_HP,
    ST_MUL_THT,
    ST_DONE
  } state_t;

  state_t state;
  state_t state_next;

  // Element counter e selects output element (i = e[1], j = e[0]);
  // k selects which of the two terms of that element is being formed.
  logic [1:0] e;
  logic       k;
  logic       idx_i;
  logic       idx_j;
  logic       last_term;

  // Operands captured at start so the caller may change them mid-run.
  logic [0:1][0:1][WIDTH-1:0] h_lat;
  logic [0:1][0:1][WIDTH-1:0] p_lat;
  logic [0:1][0:1][WIDTH-1:0] r_lat;

  // Intermediate H*P and the partially built result.
  logic [0:1][0:1][WIDTH-1:0] t_mat;
  logic [0:1][0:1][WIDTH-1:0] s_next;
  logic [0:1][0:1][WIDTH-1:0] s_final;

  logic signed [WIDTH-1:0] op_a;
  logic signed [WIDTH-1:0] op_b;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    sum;
  logic        [WIDTH-1:0] elem;
  logic        [WIDTH-1:0] s_elem;

  assign idx_i     = e[1];
  assign idx_j     = e[0];
  assign last_term = k && (e == 2'd3);
  assign done      = (state == ST_DONE);

  // Operand selection for the one shared multiplier, steered by phase, e and k.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      ST_MUL_HP: begin
        op_a = h_lat[idx_i][k];
        op_b = p_lat[k][idx_j];
      end
      ST_MUL_THT: begin
        op_a = t_mat[idx_i][k];
        op_b = h_lat[idx_j][k];
      end
      default: begin
        op_a = '0;
        op_b = '0;
      end
    endcase
  end

  // Full signed product, accumulate (fresh on k=0), scale and wrap to WIDTH.
  always_comb begin
    prod    = PW'(op_a) * PW'(op_b);
    sum     = {prod[PW-1], prod} + (k ? acc : AW'(0));
    elem    = WIDTH'(sum >>> FRAC);
    s_elem  = elem + r_lat[idx_i][idx_j];
    s_final = s_next;
    s_final[1][1] = s_elem;
  end

  // Next-state logic: idle until start, two 8-cycle product phases, one done cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = ST_MUL_HP;
      ST_MUL_HP:  if (last_term) state_next = ST_MUL_THT;
      ST_MUL_THT: if (last_term) state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Term/element counters run only in the product phases and wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e <= 2'd0;
      k <= 1'b0;
    end else if (state == ST_MUL_HP || state == ST_MUL_THT) begin
      k <= ~k;
      if (k) begin
        e <= e + 2'd1;
      end
    end else begin
      e <= 2'd0;
      k <= 1'b0;
    end
  end

  // Capture H, P and R on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_lat <= '0;
      p_lat <= '0;
      r_lat <= '0;
    end else if (state == ST_IDLE && start) begin
      h_lat <= H;
      p_lat <= P;
      r_lat <= R;
    end
  end

  // Accumulator and per-element write-back into T or the pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      t_mat  <= '0;
      s_next <= '0;
    end else begin
      if (state == ST_MUL_HP || state == ST_MUL_THT) begin
        acc <= sum;
      end
      if (state == ST_MUL_HP && k) begin
        t_mat[idx_i][idx_j] <= elem;
      end
      if (state == ST_MUL_THT && k) begin
        s_next[idx_i][idx_j] <= s_elem;
      end
    end
  end

  // Output register: updated only on the edge entering DONE. The last element
  // is finished on that same edge, so it is taken straight from the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S <= '0;
    end else if (state == ST_MUL_THT && last_term) begin
      S <= s_final;
    end
  end

endmodule

// File: tb/tb_innovation_covariance_2x2.sv
// Bench for innovation_covariance_2x2: integer and Q8 instances share the
// stimulus; expected matrices are queued when start is accepted and compared
// when done pulses, with timing and hold behaviour checked every cycle.
module tb_innovation_covariance_2x2;

  typedef logic [0:1][0:1][15:0] mat_t;

  logic clk;
  logic rst_n;
  logic start;
  mat_t h_in;
  mat_t p_in;
  mat_t r_in;
  mat_t s;
  mat_t s_q8;
  logic done;
  logic done_q8;

  int tests_run;
  int tests_failed;
  int cyc;
  mat_t s_model;
  mat_t s_model_q8;
  mat_t sbq[$];
  mat_t sbq8[$];

  innovation_covariance_2x2 #(.WIDTH(16), .FRAC(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .H(h_in), .P(p_in), .R(r_in), .S(s), .done(done)
  );

  innovation_covariance_2x2 #(.WIDTH(16), .FRAC(8)) dut_q8 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .H(h_in), .P(p_in), .R(r_in), .S(s_q8), .done(done_q8)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint wrap16(input longint v);
    logic signed [15:0] b;
    b = v[15:0];
    return longint'(b);
  endfunction

  function automatic mat_t mk(input int a, input int b, input int c, input int d);
    mat_t m;
    m[0][0] = 16'(a);
    m[0][1] = 16'(b);
    m[1][0] = 16'(c);
    m[1][1] = 16'(d);
    return m;
  endfunction

  // Reference: T = wrap((H*P) >>> frac), S = wrap(((T*H') >>> frac) + R).
  function automatic mat_t modelS(input mat_t h, input mat_t p, input mat_t r, input int frac);
    longint t[2][2];
    longint a0, a1, b0, b1, acc;
    mat_t res;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        a0 = longint'($signed(h[i][0]));
        a1 = longint'($signed(h[i][1]));
        b0 = longint'($signed(p[0][j]));
        b1 = longint'($signed(p[1][j]));
        acc = a0 * b0 + a1 * b1;
        t[i][j] = wrap16(acc >>> frac);
      end
    end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        b0 = longint'($signed(h[j][0]));
        b1 = longint'($signed(h[j][1]));
        acc = t[i][0] * b0 + t[i][1] * b1;
        acc = wrap16(acc >>> frac) + longint'($signed(r[i][j]));
        res[i][j] = acc[15:0];
      end
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Timing model: cyc counts edges since start was accepted; -1 means idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = -1;
      sbq.delete();
      sbq8.delete();
    end else if (cyc == -1) begin
      if (start) begin
        cyc = 0;
        sbq.push_back(modelS(h_in, p_in, r_in, 0));
        sbq8.push_back(modelS(h_in, p_in, r_in, 8));
      end
    end else begin
      cyc = (cyc >= 16) ? -1 : cyc + 1;
    end
  end

  // Monitor: compare done timing, result on done, and hold of S otherwise.
  always @(negedge clk) begin
    mat_t exp_m;
    if (!rst_n) begin
      s_model    = '0;
      s_model_q8 = '0;
      checkOutput("rst_s", 64'(s), 64'(0));
      checkOutput("rst_done", 64'(done), 64'(0));
    end else begin
      checkOutput("done", 64'(done), 64'(cyc == 16));
      checkOutput("done_q8", 64'(done_q8), 64'(cyc == 16));
      if (done) begin
        if (sbq.size() == 0) begin
          checkOutput("sb_empty", 64'(1), 64'(0));
        end else begin
          exp_m = sbq.pop_front();
          s_model = exp_m;
          for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
              checkOutput($sformatf("s%0d%0d", i, j), 64'(s[i][j]), 64'(exp_m[i][j]));
        end
      end else begin
        checkOutput("s_hold", 64'(s), 64'(s_model));
      end
      if (done_q8) begin
        if (sbq8.size() == 0) begin
          checkOutput("sb8_empty", 64'(1), 64'(0));
        end else begin
          exp_m = sbq8.pop_front();
          s_model_q8 = exp_m;
          for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
              checkOutput($sformatf("q8_s%0d%0d", i, j), 64'(s_q8[i][j]), 64'(exp_m[i][j]));
        end
      end else begin
        checkOutput("s_hold_q8", 64'(s_q8), 64'(s_model_q8));
      end
    end
  end

  task automatic applyStimulus(input mat_t h, input mat_t p, input mat_t r);
    @(negedge clk);
    h_in  = h;
    p_in  = p;
    r_in  = r;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for the run to finish; a stuck DUT leaves the queue non-empty.
  task automatic waitIdle();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (cyc == -1 && !start) break;
    end
    repeat (2) @(negedge clk);
    checkOutput("sb_drain", 64'(sbq.size()), 64'(0));
    checkOutput("sb8_drain", 64'(sbq8.size()), 64'(0));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    start = 1'b0;
    h_in  = '0;
    p_in  = '0;
    r_in  = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Identity H.
    applyStimulus(mk(1, 0, 0, 1), mk(4, 1, 1, 3), mk(1, 0, 0, 1));
    waitIdle();
    checkOutput("ident_const", 64'(s), 64'(mk(5, 1, 1, 4)));

    // Non-trivial H.
    applyStimulus(mk(1, 2, 0, 1), mk(1, 0, 0, 1), mk(0, 0, 0, 0));
    waitIdle();
    checkOutput("nontriv_const", 64'(s), 64'(mk(5, 2, 2, 1)));

    // Signed values.
    applyStimulus(mk(-1, 0, 0, 2), mk(3, -1, -1, 2), mk(0, 0, 0, 0));
    waitIdle();
    checkOutput("signed_const", 64'(s), 64'(mk(3, 2, 2, 8)));

    // Q8 fixed point.
    applyStimulus(mk(256, 0, 0, 256), mk(512, 0, 0, 384), mk(128, 0, 0, 128));
    waitIdle();
    checkOutput("q8_const", 64'(s_q8), 64'(mk(640, 0, 0, 512)));

    // Wrap on overflow.
    applyStimulus(mk(1, 0, 0, 1), mk(32767, 0, 0, 0), mk(1, 0, 0, 0));
    waitIdle();
    checkOutput("wrap_const", 64'(s[0][0]), 64'(16'h8000));

    // Inputs changed mid-run and extra start pulses while busy.
    applyStimulus(mk(2, 1, -3, 1), mk(5, -2, 7, 1), mk(3, 1, 1, 2));
    @(negedge clk);
    h_in = '0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle();
    repeat (20) @(negedge clk);

    // Start held high: runs back to back every 18 cycles.
    @(negedge clk);
    h_in  = mk(1, 1, 0, 1);
    p_in  = mk(2, 0, 0, 3);
    r_in  = mk(0, 0, 0, 0);
    start = 1'b1;
    repeat (20) @(negedge clk);
    h_in = mk(-2, 3, 1, 4);
    repeat (25) @(negedge clk);
    start = 1'b0;
    waitIdle();

    // Reset mid-run aborts; a fresh run afterwards completes.
    applyStimulus(mk(3, 1, 2, 5), mk(4, 1, 1, 6), mk(7, 0, 0, 7));
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_s", 64'(s), 64'(0));
    checkOutput("abort_done", 64'(done), 64'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    applyStimulus(mk(1, 0, 0, 1), mk(4, 1, 1, 3), mk(1, 0, 0, 1));
    waitIdle();
    checkOutput("post_reset_const", 64'(s), 64'(mk(5, 1, 1, 4)));

    // A few random runs.
    for (int n = 0; n < 6; n++) begin
      applyStimulus(mk($urandom_range(0, 65535), $urandom_range(0, 65535),
                       $urandom_range(0, 65535), $urandom_range(0, 65535)),
                    mk($urandom_range(0, 65535), $urandom_range(0, 65535),
                       $urandom_range(0, 65535), $urandom_range(0, 65535)),
                    mk($urandom_range(0, 65535), $urandom_range(0, 65535),
                       $urandom_range(0, 65535), $urandom_range(0, 65535)));
      waitIdle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
